// File: rtl/pulse_meas.sv
// Pulse-width decoder: counts high ticks on in, reports len with val/ovf/runt strobes.
// Optional PULSE_MEAS_SYNC_EN inserts a 2-flop input synchronizer.
module pulse_meas #(
    parameter int MAX_LENGTH_TICKS = 100,
    parameter int MIN_LENGTH_TICKS = 2,
    localparam int LW = $clog2(MAX_LENGTH_TICKS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in,
    output logic [LW-1:0] len,
    output logic          val,
    output logic          ovf,
    output logic          runt,
    output logic          busy
);

    localparam logic [LW-1:0] MAX_C = LW'(MAX_LENGTH_TICKS);
    localparam logic [LW-1:0] MIN_C = LW'(MIN_LENGTH_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEAS = 2'd1,
        OVF  = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [LW-1:0] cnt, cnt_n;
    logic [LW-1:0] len_n;
    logic          val_n, ovf_n, runt_n;
    logic          d, d_q, rise;

`ifdef PULSE_MEAS_SYNC_EN
    logic s1, s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= in;
            s2 <= s1;
        end
    end

    assign d = s2;
`else
    assign d = in;
`endif

    // d_q resets high so a pulse already in progress is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) d_q <= 1'b1;
        else      d_q <= d;
    end

    assign rise = d & ~d_q;
    assign busy = (state == MEAS) || (state == OVF);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            len   <= '0;
            val   <= 1'b0;
            ovf   <= 1'b0;
            runt  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            len   <= len_n;
            val   <= val_n;
            ovf   <= ovf_n;
            runt  <= runt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        len_n   = len;
        val_n   = 1'b0;
        ovf_n   = 1'b0;
        runt_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    cnt_n   = LW'(1);
                    state_n = MEAS;
                end
            end
            MEAS: begin
                if (d) begin
                    if (cnt == MAX_C) begin
                        ovf_n   = 1'b1;
                        state_n = OVF;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    state_n = IDLE;
                    if (cnt >= MIN_C) begin
                        len_n = cnt;
                        val_n = 1'b1;
                    end else begin
                        runt_n = 1'b1;
                    end
                end
            end
            OVF: begin
                if (!d) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pulse_meas.sv
// Scoreboard bench for pulse_meas (default build, MAX=100, MIN=2).
// Stimulus pushes expected strobes; a negedge monitor pops and compares.
module tb_pulse_meas;

    localparam int KV = 4;
    localparam int KO = 2;
    localparam int KR = 1;

    typedef struct {
        logic [2:0] kind;
        int         len;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       in;
    logic [6:0] len;
    logic       val, ovf, runt, busy;

    exp_t exp_q[$];
    int   tests;
    int   fails;

    pulse_meas #(
        .MAX_LENGTH_TICKS(100),
        .MIN_LENGTH_TICKS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .len (len),
        .val (val),
        .ovf (ovf),
        .runt(runt),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic v, input int n);
        repeat (n) begin
            in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ev(input logic [2:0] k, input int l);
        exp_t e;
        e.kind = k;
        e.len  = l;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [2:0] got;
        got = {val, ovf, runt};
        if (got != 3'b000) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe strobes=%b len=%0d", got, len);
            end else begin
                e = exp_q.pop_front();
                if (got != e.kind || int'(len) != e.len) begin
                    fails++;
                    $display("FAIL strobe got=%b len=%0d expected=%b len=%0d",
                             got, len, e.kind, e.len);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst   = 1'b0;
        in    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({len, val, ovf, runt, busy}), 0);
        rst = 1'b1;

        // pulse high at reset release is ignored
        cyc(1'b1, 10);
        chk("ignore_initial_high", int'(busy), 0);
        cyc(1'b0, 3);
        expect_ev(3'(KV), 40);
        cyc(1'b1, 40);
        cyc(1'b0, 3);
        chk("idle_after_40", int'(busy), 0);

        expect_ev(3'(KR), 40);
        cyc(1'b1, 1);
        cyc(1'b0, 3);
        chk("len_held_after_runt", int'(len), 40);

        expect_ev(3'(KV), 2);
        cyc(1'b1, 2);
        cyc(1'b0, 3);

        expect_ev(3'(KV), 100);
        cyc(1'b1, 100);
        cyc(1'b0, 3);

        expect_ev(3'(KO), 100);
        cyc(1'b1, 100);
        chk("no_ovf_at_100", int'(ovf), 0);
        cyc(1'b1, 1);
        chk("ovf_at_101", int'(ovf), 1);
        cyc(1'b1, 49);
        chk("busy_in_ovf", int'(busy), 1);
        cyc(1'b0, 2);
        chk("idle_after_ovf", int'(busy), 0);
        expect_ev(3'(KV), 5);
        cyc(1'b1, 5);
        cyc(1'b0, 3);

        expect_ev(3'(KV), 10);
        expect_ev(3'(KV), 20);
        cyc(1'b1, 10);
        cyc(1'b0, 1);
        cyc(1'b1, 20);
        cyc(1'b0, 3);

        cyc(1'b1, 30);
        chk("busy_mid_pulse", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", int'({len, val, ovf, runt, busy}), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b1, 29);
        chk("ignore_after_reset", int'(busy), 0);
        cyc(1'b0, 2);
        expect_ev(3'(KV), 7);
        cyc(1'b1, 7);
        cyc(1'b0, 5);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
